// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between a UART and an ALU: receives AA/A/B/OP/CHK frames, drives the ALU
// operands, then transmits a status byte (K/E) followed by the result byte.
module uart_alu_sequencer #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic             i_tx_done,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_operation,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [DBIT-1:0] SOF = DBIT'(8'hAA);
    localparam logic [DBIT-1:0] ACK = DBIT'(8'h4B);
    localparam logic [DBIT-1:0] NAK = DBIT'(8'h45);

    typedef enum logic [3:0] {
        StIdle, StRxA, StRxB, StRxOp, StRxChk, StExec, StTxStat, StWaitStat, StTxRes, StWaitRes
    } state_e;

    state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DBIT-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_op_q, sh_op_d;
    logic [DBIT-1:0]  data_a_q, data_a_d, data_b_q, data_b_d;
    logic [NB_OP-1:0] op_q, op_d;
    logic [DBIT-1:0]  result_q, result_d, tx_data_q, tx_data_d;
    logic             err_q, err_d, chk_ok_q, chk_ok_d;
    logic             tx_start;
    logic             in_rx;
    logic             expire;

    assign in_rx  = (state_q == StRxA) || (state_q == StRxB) ||
                    (state_q == StRxOp) || (state_q == StRxChk);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire = in_rx && !i_rx_done && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        sh_op_d   = sh_op_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        op_d      = op_q;
        result_d  = result_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        chk_ok_d  = chk_ok_q;
        tx_start  = 1'b0;

        if (i_rx_done || !in_rx || expire) begin
            cnt_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (i_rx_done && (i_rx_data == SOF)) state_d = StRxA;
            end
            StRxA, StRxB, StRxOp: begin
                if (i_rx_done) begin
                    if (state_q == StRxA) begin
                        sh_a_d  = i_rx_data;
                        state_d = StRxB;
                    end else if (state_q == StRxB) begin
                        sh_b_d  = i_rx_data;
                        state_d = StRxOp;
                    end else begin
                        sh_op_d = i_rx_data;
                        state_d = StRxChk;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StRxChk: begin
                if (i_rx_done) begin
                    state_d = StExec;
                    if (i_rx_data == (sh_a_q ^ sh_b_q ^ sh_op_q)) begin
                        chk_ok_d = 1'b1;
                        data_a_d = sh_a_q;
                        data_b_d = sh_b_q;
                        op_d     = sh_op_q[NB_OP-1:0];
                        err_d    = 1'b0;
                    end else begin
                        chk_ok_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StExec: begin
                result_d  = chk_ok_q ? i_alu_result : '0;
                tx_data_d = chk_ok_q ? ACK : NAK;
                state_d   = StTxStat;
            end
            StTxStat: begin
                tx_start = 1'b1;
                state_d  = StWaitStat;
            end
            StWaitStat: begin
                if (i_tx_done) begin
                    tx_data_d = result_q;
                    state_d   = StTxRes;
                end
            end
            StTxRes: begin
                tx_start = 1'b1;
                state_d  = StWaitRes;
            end
            StWaitRes: begin
                if (i_tx_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            sh_op_q   <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            op_q      <= '0;
            result_q  <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            chk_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            sh_op_q   <= sh_op_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
            chk_ok_q  <= chk_ok_d;
        end
    end

    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    assign o_operation = op_q;
    assign o_tx_start  = tx_start;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = (state_q != StIdle);
    assign o_err       = err_q;

endmodule
